// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and default sizing for the instruction fetch unit.
package riscv_pkg;
  localparam int FETCH_XLEN = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int FETCH_MAX_OUTSTANDING = 2;
  localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  // empty head reads as zero so the outputs rest at their reset values
  assign head = (count != '0) ? mem[rd] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited sequential instruction fetch with redirect flush
// and drop accounting for responses that were in flight at the redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                XLEN            = FETCH_XLEN,
  parameter int                DEPTH           = FETCH_DEPTH,
  parameter int                MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [XLEN-1:0]   RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0]   outstanding, drop_cnt, outstanding_next;
  logic [FW-1:0]   fifo_count;
  logic            req_fire, push, pop, unused_bits;
  fetch_entry_t    head, din;
  assign redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];
  // every in-flight request holds a buffer slot, so the FIFO can never overflow
  assign imem_req_valid = !rst && !redirect_valid
                        && 32'(outstanding) < 32'(MAX_OUTSTANDING)
                        && 32'(outstanding) + 32'(fifo_count) < 32'(DEPTH);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop = out_valid && out_ready;
  assign push = imem_rsp_valid && drop_cnt == '0 && !redirect_valid;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign din = '{pc: rsp_pc, instr: imem_rsp_data, fault: imem_rsp_err};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc <= redir_pc;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) rsp_pc <= rsp_pc + XLEN'(4);
      end
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .din  (din),
    .head (head),
    .count(fifo_count)
  );
  assign out_valid = fifo_count != '0;
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of the fetch unit against an in-order memory model
// and an expected-PC scoreboard on the consumer side.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int lat_min = 1;
  int lat_max = 1;
  int p0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;
  logic [31:0] exp_pc;
  logic fire_s, rsp_s;
  logic [31:0] addr_s;
  bit found;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t q[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_fault     (out_fault)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // handshakes are sampled mid-cycle, where every input is already settled
  always @(negedge clk) begin
    fire_s = imem_req_valid && imem_req_ready;
    rsp_s = imem_rsp_valid;
    addr_s = imem_req_addr;
  end

  // in-order memory with per-request latency in [lat_min, lat_max]
  always @(posedge clk) begin
    cyc++;
    if (rst) q.delete();
    else begin
      if (rsp_s) void'(q.pop_front());
      if (fire_s) q.push_back('{addr: addr_s, due: cyc + int'($urandom_range(lat_max - 1, lat_min - 1))});
    end
    #1;
    if (!rst && q.size() != 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = img(q[0].addr);
      imem_rsp_err = q[0].addr == err_addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      imem_rsp_err = 1'b0;
    end
  end

  // consumer scoreboard: every popped entry must be the next expected PC
  always @(negedge clk) begin
    if (rst) exp_pc = 32'h0;
    else begin
      if (out_valid && out_ready) begin
        check("sb_pc", out_pc, exp_pc);
        check("sb_instr", out_instr, img(exp_pc));
        check("sb_fault", out_fault, exp_pc == err_addr);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_fault", out_fault, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("c0_req_valid", imem_req_valid, 1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    check("c1_out_valid", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("tput_valid", out_valid, 1);
      check("tput_pc", out_pc, 32'(4 * k));
    end

    // stall the consumer: buffer fills to DEPTH and issue stops
    step();
    out_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("stall_valid", out_valid, 1);
    check("stall_noreq", imem_req_valid, 0);
    step();
    imem_req_ready = 1'b0;
    out_ready = 1'b1;
    p0 = pops;
    repeat (8) step();
    check("stall_buffered", pops - p0, 4);
    check("stall_drained", out_valid, 0);
    imem_req_ready = 1'b1;
    repeat (5) step();

    // redirect with two slow responses outstanding and two entries buffered
    lat_min = 6;
    lat_max = 6;
    out_ready = 1'b0;
    repeat (14) step();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    repeat (2) step();
    check("pre_redir_outst", q.size(), 2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("redir_noreq", imem_req_valid, 0);
    step();
    redirect_valid = 1'b0;
    check("redir_drop2", dut.drop_cnt, 2);
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = out_valid;
    end
    check("redir_found", found, 1);
    check("redir_first_pc", out_pc, 32'h100);

    // redirect in the same cycle as a response, unaligned target
    lat_min = 2;
    lat_max = 2;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = q.size() == 2 && imem_rsp_valid;
    end
    check("same_cyc_found", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    check("same_cyc_drop1", dut.drop_cnt, 1);
    @(negedge clk);
    check("rplus1_req_valid", imem_req_valid, 1);
    check("rplus1_req_addr", imem_req_addr, 32'h200);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = out_valid;
    end
    check("align_found", found, 1);
    check("align_first_pc", out_pc, 32'h200);

    // fault pass-through, then reset in the middle of the burst
    lat_min = 1;
    lat_max = 1;
    err_addr = 32'h8;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = out_valid && out_pc == 32'h8;
    end
    check("fault_found", found, 1);
    check("fault_set", out_fault, 1);
    step();
    check("after_fault_pc", out_pc, 32'hC);
    check("after_fault_clr", out_fault, 0);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", imem_req_valid, 0);
    check("mid_rst_req_addr", imem_req_addr, 32'h0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_pc", out_pc, 0);
    check("mid_rst_out_instr", out_instr, 0);
    check("mid_rst_out_fault", out_fault, 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_addr", imem_req_addr, 32'h0);

    // random readiness, latency and redirects, including back-to-back ones
    err_addr = 32'h10;
    lat_min = 1;
    lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      step();
      check("outst_le2", q.size() <= 2, 1);
      check("fifo_le4", dut.fifo_count <= 4, 1);
      imem_req_ready = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc = 32'($urandom_range(0, 255));
    end
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (10) step();
    p0 = pops;
    repeat (20) step();
    check("drain_flow", pops - p0 >= 18, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
